// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external SRAM bus master.
// Contents: bus-cycle state enum, access-size encodings, wait-counter
// width and a helper that flags requests which must not start a bus cycle.
package ext_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_TW   = 3'd3,
      S_T3   = 3'd4
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // Wide enough for WAIT_STATES up to 15
   localparam int WCNT_W = 4;

   // Reserved size or an address not aligned to the access size
   function automatic logic req_bad(input logic [1:0] sz, input logic [1:0] a);
      return (sz == SZ_RSVD) ||
             ((sz == SZ_HALF) && a[0]) ||
             ((sz == SZ_WORD) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/ext_sram_waitctr.sv
// Wait-state counter for the TW phase.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   load       - preload with WAIT_STATES-1 (asserted in T2)
//   run        - count down while in TW
//   ext_rdy    - external ready; low holds the final TW cycle when RDY_EN=1
//   tw_last    - this TW cycle is the one that leaves TW on the next edge
module ext_sram_waitctr
   import ext_bus_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int RDY_EN      = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic load,
   input  logic run,
   input  logic ext_rdy,
   output logic tw_last
);

   logic [WCNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= WCNT_W'(WAIT_STATES - 1);
      end else if (run && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - WCNT_W'(1);
      end
   end

   // The counter parks at zero; ext_rdy only matters once it gets there
   assign tw_last = (cnt_reg == '0) && ((RDY_EN == 0) || ext_rdy);

endmodule

// File: rtl/ext_sram_bus.sv
// External SRAM bus master with a multiplexed 16-bit address/data bus.
// A CPU request (valid/ready handshake) becomes one bus cycle
// T1 (addr low) -> T2 (addr high) -> TW x WAIT_STATES -> T3, or two such
// cycles for a 32-bit word. Completion is a one-cycle done pulse in IDLE.
// Ports:
//   clk, rstn                 - clock, synchronous active-low reset
//   valid/ready, rw, size,
//   addri, dtw                - CPU request side
//   dtr, done, err            - CPU completion side
//   din, dout, isout          - multiplexed bus data and direction
//   we, oe, ble, bhe          - posedge-timed strobes and byte lanes
//   oe_negedge, ale0_negedge,
//   ale1_negedge              - strobes shifted by half a clock
//   ext_rdy                   - external wait request
module ext_sram_bus
   import ext_bus_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int RDY_EN      = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        valid,
   output logic        ready,
   input  logic        rw,
   input  logic [1:0]  size,
   input  logic [31:0] addri,
   input  logic [31:0] dtw,
   output logic [31:0] dtr,
   output logic        done,
   output logic        err,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        isout,
   output logic        we,
   output logic        oe,
   output logic        oe_negedge,
   output logic        ale0_negedge,
   output logic        ale1_negedge,
   output logic        ble,
   output logic        bhe,
   input  logic        ext_rdy
);

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, dtw_reg, dtr_reg;
   logic [1:0]  size_reg;
   logic        rw_reg, half_reg;
   logic [15:0] lo_reg;
   logic        done_reg, err_reg, run_reg;
   logic        ale0_reg, ale1_reg, oen_reg;
   logic        accept, word_first, tw_last;
   logic        lane_lo, lane_hi;
   logic [15:0] wr_half;
   logic [31:0] rd_data;

   // run_reg is low on the cycle after any reset edge; it keeps ready low
   // until the first edge with rstn high and masks the negedge strobes
   // immediately when a transfer is aborted.
   assign ready      = run_reg && (state_reg == S_IDLE);
   assign accept     = valid && ready;
   assign word_first = (size_reg == SZ_WORD) && !half_reg;

   ext_sram_waitctr #(
      .WAIT_STATES(WAIT_STATES),
      .RDY_EN     (RDY_EN)
   ) u_waitctr (
      .clk    (clk),
      .rstn   (rstn),
      .load   (state_reg == S_T2),
      .run    (state_reg == S_TW),
      .ext_rdy(ext_rdy),
      .tw_last(tw_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept && !req_bad(size, addri[1:0])) state_next = S_T1;
         S_T1:    state_next = S_T2;
         S_T2:    state_next = S_TW;
         S_TW:    if (tw_last) state_next = S_T3;
         S_T3:    state_next = word_first ? S_T1 : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Lane selection, write halfword and read-data assembly
   always_comb begin
      lane_lo = 1'b1;
      lane_hi = 1'b1;
      wr_half = dtw_reg[15:0];
      rd_data = {16'h0000, din};
      case (size_reg)
         SZ_BYTE: begin
            lane_lo = !addr_reg[0];
            lane_hi = addr_reg[0];
            wr_half = addr_reg[0] ? {dtw_reg[7:0], 8'h00} : {8'h00, dtw_reg[7:0]};
            rd_data = addr_reg[0] ? {24'h0, din[15:8]} : {24'h0, din[7:0]};
         end
         SZ_WORD: begin
            wr_half = half_reg ? dtw_reg[31:16] : dtw_reg[15:0];
            rd_data = {din, lo_reg};
         end
         default: ;
      endcase
   end

   // Bus outputs decoded from the current state
   always_comb begin
      dout  = 16'h0000;
      isout = 1'b0;
      we    = 1'b0;
      oe    = 1'b0;
      ble   = 1'b0;
      bhe   = 1'b0;
      case (state_reg)
         S_T1: begin
            dout  = addr_reg[16:1];
            isout = 1'b1;
         end
         S_T2: begin
            dout  = {1'b0, addr_reg[31:17]};
            isout = 1'b1;
            we    = rw_reg;
         end
         S_TW: begin
            dout  = rw_reg ? wr_half : 16'h0000;
            isout = rw_reg;
            we    = rw_reg;
            oe    = !rw_reg;
            ble   = lane_lo;
            bhe   = lane_hi;
         end
         default: ;
      endcase
   end

   // Request latch, read capture and completion
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_reg <= '0;
         dtw_reg  <= '0;
         rw_reg   <= 1'b0;
         size_reg <= SZ_BYTE;
         half_reg <= 1'b0;
         lo_reg   <= '0;
         dtr_reg  <= '0;
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         run_reg  <= 1'b0;
      end else begin
         run_reg  <= 1'b1;
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  addr_reg <= addri;
                  dtw_reg  <= dtw;
                  rw_reg   <= rw;
                  size_reg <= size;
                  half_reg <= 1'b0;
                  if (req_bad(size, addri[1:0])) begin
                     done_reg <= 1'b1;
                     err_reg  <= 1'b1;
                     dtr_reg  <= '0;
                  end
               end
            end
            // Sample din on the edge that ends TW, while oe is still high
            S_TW: begin
               if (tw_last && !rw_reg) begin
                  if (word_first) lo_reg  <= din;
                  else            dtr_reg <= rd_data;
               end
            end
            S_T3: begin
               if (word_first) begin
                  half_reg <= 1'b1;
                  addr_reg <= addr_reg + 32'd2;
               end else begin
                  done_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Half-cycle-shifted strobes: ale0 rises at the negedge before T1,
   // ale1 covers the negedge-to-negedge window around T2, oe_negedge from
   // the negedge in T2 until the negedge in T3.
   always_ff @(negedge clk) begin
      if (!rstn) begin
         ale0_reg <= 1'b0;
         ale1_reg <= 1'b0;
         oen_reg  <= 1'b0;
      end else begin
         ale0_reg <= (state_next == S_T1);
         ale1_reg <= (state_reg == S_T1);
         oen_reg  <= (state_reg == S_T2) || (state_reg == S_TW);
      end
   end

   assign ale0_negedge = ale0_reg && run_reg;
   assign ale1_negedge = ale1_reg && run_reg;
   assign oe_negedge   = oen_reg && run_reg;
   assign dtr          = dtr_reg;
   assign done         = done_reg;
   assign err          = err_reg;

endmodule

// File: tb/tb_ext_sram_bus.sv
`timescale 1ns/1ps
module tb_ext_sram_bus;
   import ext_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        valid = 1'b0;
   logic        rw = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addri = 32'h0;
   logic [31:0] dtw = 32'h0;
   logic [15:0] din = 16'h0;
   logic        ext_rdy = 1'b1;

   // dut a: WAIT_STATES=1, RDY_EN=1
   logic        a_ready, a_done, a_err, a_isout, a_we, a_oe, a_oen, a_ale0, a_ale1, a_ble, a_bhe;
   logic [31:0] a_dtr;
   logic [15:0] a_dout;
   // dut b: WAIT_STATES=2, RDY_EN=0
   logic        b_ready, b_done, b_err, b_isout, b_we, b_oe, b_oen, b_ale0, b_ale1, b_ble, b_bhe;
   logic [31:0] b_dtr;
   logic [15:0] b_dout;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ext_sram_bus #(.WAIT_STATES(1), .RDY_EN(1)) dut_a (
      .clk(clk), .rstn(rstn), .valid(valid), .ready(a_ready), .rw(rw), .size(size),
      .addri(addri), .dtw(dtw), .dtr(a_dtr), .done(a_done), .err(a_err), .din(din),
      .dout(a_dout), .isout(a_isout), .we(a_we), .oe(a_oe), .oe_negedge(a_oen),
      .ale0_negedge(a_ale0), .ale1_negedge(a_ale1), .ble(a_ble), .bhe(a_bhe), .ext_rdy(ext_rdy)
   );

   ext_sram_bus #(.WAIT_STATES(2), .RDY_EN(0)) dut_b (
      .clk(clk), .rstn(rstn), .valid(valid), .ready(b_ready), .rw(rw), .size(size),
      .addri(addri), .dtw(dtw), .dtr(b_dtr), .done(b_done), .err(b_err), .din(din),
      .dout(b_dout), .isout(b_isout), .we(b_we), .oe(b_oe), .oe_negedge(b_oen),
      .ale0_negedge(b_ale0), .ale1_negedge(b_ale1), .ble(b_ble), .bhe(b_bhe), .ext_rdy(ext_rdy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; returns 1ns after the accept edge (cycle c0)
   task automatic start(input logic r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      valid = 1'b1; rw = r; size = s; addri = a; dtw = d;
      $display("[TB] request rw=%b size=%b addr=%h dtw=%h", r, s, a, d);
      tick();
      valid = 1'b0;
   endtask

   task automatic wait_idle;
      int i;
      i = 0;
      while (!((a_ready === 1'b1) && (b_ready === 1'b1)) && (i < 40)) begin
         tick();
         i++;
      end
      n_tests++;
      if (i >= 40) begin
         n_fail++;
         $display("FAIL idle_timeout: a_ready=%b b_ready=%b, required both 1", a_ready, b_ready);
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({a_ready, a_done, a_err, a_isout, a_we, a_oe, a_oen, a_ale0, a_ale1, a_ble, a_bhe} !== 11'h0 ||
          a_dout !== 16'h0 || a_dtr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_a_outputs: ctl=%b dout=%h dtr=%h, required all 0",
                  {a_ready, a_done, a_err, a_isout, a_we, a_oe, a_oen, a_ale0, a_ale1, a_ble, a_bhe}, a_dout, a_dtr);
      end
      n_tests++;
      if ({b_ready, b_done, b_err, b_isout, b_we, b_oe, b_oen, b_ale0, b_ale1, b_ble, b_bhe} !== 11'h0 ||
          b_dout !== 16'h0 || b_dtr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_b_outputs: ctl=%b dout=%h dtr=%h, required all 0",
                  {b_ready, b_done, b_err, b_isout, b_we, b_oe, b_oen, b_ale0, b_ale1, b_ble, b_bhe}, b_dout, b_dtr);
      end
      rstn = 1'b1;
      tick();
      n_tests++;
      if ({a_ready, b_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_ready_after: got %b, required 11", {a_ready, b_ready});
      end
   endtask

   task automatic test_half_read;
      din = 16'hBEEF;
      start(1'b0, SZ_HALF, 32'h0001_2344, 32'h0);
      n_tests++;
      if ({a_dout, a_isout, a_ale0, a_ready} !== {16'h91A2, 3'b110}) begin
         n_fail++;
         $display("FAIL hr_t1: dout=%h isout=%b ale0=%b ready=%b, required 91a2 1 1 0", a_dout, a_isout, a_ale0, a_ready);
      end
      tick();
      n_tests++;
      if ({a_dout, a_ale0, a_ale1, a_we} !== {16'h0000, 3'b010}) begin
         n_fail++;
         $display("FAIL hr_t2: dout=%h ale0=%b ale1=%b we=%b, required 0000 0 1 0", a_dout, a_ale0, a_ale1, a_we);
      end
      tick();
      n_tests++;
      if ({a_oe, a_isout, a_ble, a_bhe, a_oen, a_ale1} !== 6'b101110) begin
         n_fail++;
         $display("FAIL hr_tw: oe,isout,ble,bhe,oen,ale1=%b, required 101110", {a_oe, a_isout, a_ble, a_bhe, a_oen, a_ale1});
      end
      tick();
      n_tests++;
      if ({a_oe, a_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL hr_t3: oe,done=%b, required 00", {a_oe, a_done});
      end
      tick();
      n_tests++;
      if ({a_done, a_err, a_ready} !== 3'b101 || a_dtr !== 32'h0000_BEEF) begin
         n_fail++;
         $display("FAIL hr_done: done,err,ready=%b dtr=%h, required 101 0000beef", {a_done, a_err, a_ready}, a_dtr);
      end
      wait_idle();
   endtask

   task automatic test_word_write;
      logic [10:0] we_exp;
      logic [10:0] done_exp;
      we_exp   = 11'h1CE;   // T2,TW,TW of each half
      done_exp = 11'h400;
      start(1'b1, SZ_WORD, 32'h0000_0100, 32'hCAFE_BABE);
      for (int c = 0; c <= 10; c++) begin
         n_tests++;
         if (b_we !== we_exp[c]) begin
            n_fail++;
            $display("FAIL ww_we c%0d: got %b, required %b", c, b_we, we_exp[c]);
         end
         n_tests++;
         if (b_done !== done_exp[c]) begin
            n_fail++;
            $display("FAIL ww_done c%0d: got %b, required %b", c, b_done, done_exp[c]);
         end
         if (c == 0) begin
            n_tests++;
            if (b_dout !== 16'h0080) begin
               n_fail++;
               $display("FAIL ww_t1a_dout: got %h, required 0080", b_dout);
            end
         end
         if (c == 2) begin
            n_tests++;
            if ({b_dout, b_isout, b_ble, b_bhe} !== {16'hBABE, 3'b111}) begin
               n_fail++;
               $display("FAIL ww_tw1: dout=%h isout,ble,bhe=%b, required babe 111", b_dout, {b_isout, b_ble, b_bhe});
            end
         end
         if (c == 5) begin
            n_tests++;
            if (b_dout !== 16'h0081) begin
               n_fail++;
               $display("FAIL ww_t1b_dout: got %h, required 0081", b_dout);
            end
         end
         if (c == 7) begin
            n_tests++;
            if (b_dout !== 16'hCAFE) begin
               n_fail++;
               $display("FAIL ww_tw2_dout: got %h, required cafe", b_dout);
            end
         end
         if (c == 10) begin
            n_tests++;
            if (b_err !== 1'b0 || b_dtr !== 32'h0000_BEEF) begin
               n_fail++;
               $display("FAIL ww_end: err=%b dtr=%h, required 0 0000beef", b_err, b_dtr);
            end
         end
         if (c < 10) tick();
      end
      wait_idle();
   endtask

   task automatic test_byte_lanes;
      logic        v_rw   [4];
      logic [31:0] v_addr [4];
      logic [31:0] v_dtw  [4];
      logic [15:0] v_dout [4];
      logic [1:0]  v_lane [4];
      logic [31:0] v_dtr  [4];
      v_rw   = '{1'b0, 1'b0, 1'b1, 1'b1};
      v_addr = '{32'h3, 32'h4, 32'h6, 32'h7};
      v_dtw  = '{32'h0, 32'h0, 32'h1122_3377, 32'h0000_0055};
      v_dout = '{16'h0000, 16'h0000, 16'h0077, 16'h5500};
      v_lane = '{2'b01, 2'b10, 2'b10, 2'b01};
      v_dtr  = '{32'h5A, 32'hC3, 32'hC3, 32'hC3};
      din = 16'h5AC3;
      for (int i = 0; i < 4; i++) begin
         start(v_rw[i], SZ_BYTE, v_addr[i], v_dtw[i]);
         tick();
         tick();
         n_tests++;
         if ({a_ble, a_bhe} !== v_lane[i] || a_dout !== v_dout[i] || a_isout !== v_rw[i] || a_oe !== !v_rw[i]) begin
            n_fail++;
            $display("FAIL byte_tw %0d: ble,bhe=%b dout=%h isout=%b oe=%b, required %b %h %b %b",
                     i, {a_ble, a_bhe}, a_dout, a_isout, a_oe, v_lane[i], v_dout[i], v_rw[i], !v_rw[i]);
         end
         tick();
         tick();
         n_tests++;
         if (a_done !== 1'b1 || a_dtr !== v_dtr[i]) begin
            n_fail++;
            $display("FAIL byte_done %0d: done=%b dtr=%h, required 1 %h", i, a_done, a_dtr, v_dtr[i]);
         end
         wait_idle();
      end
   endtask

   task automatic test_error;
      logic [1:0]  v_size [3];
      logic [31:0] v_addr [3];
      v_size = '{SZ_HALF, SZ_RSVD, SZ_WORD};
      v_addr = '{32'h1, 32'h0, 32'h2};
      for (int i = 0; i < 3; i++) begin
         start(i[0], v_size[i], v_addr[i], 32'h1234_5678);
         n_tests++;
         if ({a_done, a_err, a_ready} !== 3'b111 || a_dtr !== 32'h0 || b_dtr !== 32'h0) begin
            n_fail++;
            $display("FAIL err_done %0d: done,err,ready=%b dtr a=%h b=%h, required 111 0 0",
                     i, {a_done, a_err, a_ready}, a_dtr, b_dtr);
         end
         n_tests++;
         if ({a_isout, a_we, a_oe, a_ale0, b_isout, b_ale0} !== 6'b0) begin
            n_fail++;
            $display("FAIL err_nobus %0d: got %b, required 000000", i, {a_isout, a_we, a_oe, a_ale0, b_isout, b_ale0});
         end
         tick();
         n_tests++;
         if ({a_done, a_err, a_isout, a_ale0, a_ale1} !== 5'b0) begin
            n_fail++;
            $display("FAIL err_after %0d: done,err,isout,ale0,ale1=%b, required 00000", i, {a_done, a_err, a_isout, a_ale0, a_ale1});
         end
         wait_idle();
      end
   endtask

   task automatic test_rdy_stretch;
      logic [7:0] a_done_exp;
      logic [7:0] b_done_exp;
      logic [7:0] a_oe_exp;
      a_done_exp = 8'h80;
      b_done_exp = 8'h20;
      a_oe_exp   = 8'h3C;
      din = 16'h1234;
      start(1'b0, SZ_HALF, 32'h0000_0010, 32'h0);
      for (int c = 0; c <= 7; c++) begin
         n_tests++;
         if ({a_done, b_done, a_oe} !== {a_done_exp[c], b_done_exp[c], a_oe_exp[c]}) begin
            n_fail++;
            $display("FAIL rdy c%0d: a_done,b_done,a_oe=%b, required %b", c, {a_done, b_done, a_oe},
                     {a_done_exp[c], b_done_exp[c], a_oe_exp[c]});
         end
         if (c == 2) ext_rdy = 1'b0;
         if (c == 5) ext_rdy = 1'b1;
         if (c < 7) tick();
      end
      n_tests++;
      if (a_dtr !== 32'h1234 || b_dtr !== 32'h1234) begin
         n_fail++;
         $display("FAIL rdy_dtr: a=%h b=%h, required 00001234", a_dtr, b_dtr);
      end
      wait_idle();
   endtask

   task automatic test_word_read;
      din = 16'h2222;
      start(1'b0, SZ_WORD, 32'h0000_0200, 32'h0);
      for (int c = 0; c <= 8; c++) begin
         n_tests++;
         if (a_done !== (c == 8)) begin
            n_fail++;
            $display("FAIL wr_done c%0d: got %b, required %b", c, a_done, (c == 8));
         end
         if (c == 4) begin
            n_tests++;
            if (a_dout !== 16'h0101 || a_ale0 !== 1'b1) begin
               n_fail++;
               $display("FAIL wr_t1b: dout=%h ale0=%b, required 0101 1", a_dout, a_ale0);
            end
         end
         if (c == 3) din = 16'hDDDD;
         if (c < 8) tick();
      end
      n_tests++;
      if (a_dtr !== 32'hDDDD_2222 || a_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_dtr: dtr=%h err=%b, required dddd2222 0", a_dtr, a_err);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back;
      din = 16'hA53C;
      start(1'b0, SZ_HALF, 32'h0000_0020, 32'h0);
      repeat (4) tick();
      n_tests++;
      if ({a_done, a_ready, b_ready} !== 3'b110 || a_dtr !== 32'hA53C) begin
         n_fail++;
         $display("FAIL b2b_first: a_done,a_ready,b_ready=%b dtr=%h, required 110 0000a53c", {a_done, a_ready, b_ready}, a_dtr);
      end
      start(1'b0, SZ_BYTE, 32'h0000_0022, 32'h0);
      n_tests++;
      if ({a_isout, a_done, b_done} !== 3'b101 || a_dout !== 16'h0011 || b_dtr !== 32'hA53C) begin
         n_fail++;
         $display("FAIL b2b_second_t1: a_isout,a_done,b_done=%b a_dout=%h b_dtr=%h, required 101 0011 0000a53c",
                  {a_isout, a_done, b_done}, a_dout, b_dtr);
      end
      tick();
      n_tests++;
      if ({b_isout, b_done, b_ready, b_ale1} !== 4'b0010) begin
         n_fail++;
         $display("FAIL b2b_ignored: b isout,done,ready,ale1=%b, required 0010", {b_isout, b_done, b_ready, b_ale1});
      end
      repeat (3) tick();
      n_tests++;
      if (a_done !== 1'b1 || a_dtr !== 32'h3C) begin
         n_fail++;
         $display("FAIL b2b_second_done: done=%b dtr=%h, required 1 0000003c", a_done, a_dtr);
      end
      wait_idle();
   endtask

   task automatic test_reset_abort;
      start(1'b1, SZ_WORD, 32'h0000_0300, 32'h89AB_CDEF);
      repeat (6) tick();
      n_tests++;
      if (b_we !== 1'b1 || b_dout !== 16'h0000 || b_ale1 !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_t2b: we=%b dout=%h ale1=%b, required 1 0000 1", b_we, b_dout, b_ale1);
      end
      rstn = 1'b0;
      tick();
      n_tests++;
      if ({b_ready, b_done, b_err, b_isout, b_we, b_oe, b_oen, b_ale0, b_ale1, b_ble, b_bhe} !== 11'h0 ||
          b_dout !== 16'h0 || b_dtr !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_b_outputs: ctl=%b dout=%h dtr=%h, required all 0",
                  {b_ready, b_done, b_err, b_isout, b_we, b_oe, b_oen, b_ale0, b_ale1, b_ble, b_bhe}, b_dout, b_dtr);
      end
      n_tests++;
      if ({a_ready, a_done, a_isout, a_we, a_oe, a_oen, a_ale0, a_ale1, a_ble, a_bhe} !== 10'h0 || a_dout !== 16'h0) begin
         n_fail++;
         $display("FAIL abort_a_outputs: ctl=%b dout=%h, required all 0",
                  {a_ready, a_done, a_isout, a_we, a_oe, a_oen, a_ale0, a_ale1, a_ble, a_bhe}, a_dout);
      end
      tick();
      rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++;
         if ({a_done, b_done, b_isout} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_no_done %0d: a_done,b_done,b_isout=%b, required 000", c, {a_done, b_done, b_isout});
         end
      end
      n_tests++;
      if (b_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_ready: got %b, required 1", b_ready);
      end
      din = 16'h4321;
      start(1'b0, SZ_HALF, 32'h0000_0008, 32'h0);
      repeat (5) tick();
      n_tests++;
      if (b_done !== 1'b1 || b_err !== 1'b0 || b_dtr !== 32'h4321) begin
         n_fail++;
         $display("FAIL abort_recover: done=%b err=%b dtr=%h, required 1 0 00004321", b_done, b_err, b_dtr);
      end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_half_read();
      test_word_write();
      test_byte_lanes();
      test_error();
      test_rdy_stretch();
      test_word_read();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ext_sram_bus.md
Name: ext_sram_bus

Overview:
- Second-generation external SRAM bus master: multiplexed 16-bit address/data bus, ALE0/ALE1 address latch strobes, active-high control outputs.
- Adds parametrised wait states, external ready stretching, byte/halfword/word sizes with BLE/BHE lane control, and automatic split of 32-bit accesses into two halfword bus cycles.
- Sits between the CPU memory request port and the board-level SRAM/latch pins.

Parameters:
- WAIT_STATES, 1, number of TW cycles per bus cycle (legal 1..15).
- RDY_EN, 1, when 1, ext_rdy low stretches TW; when 0, ext_rdy is ignored.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- valid  in  1  request strobe
- ready  out  1  high in IDLE; request accepted on posedge when valid&ready
- rw  in  1  1=write, 0=read
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- addri  in  32  byte address
- dtw  in  32  write data, right-aligned
- dtr  out  32  read data, right-aligned, zero-extended
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; misaligned or reserved size
- din  in  16  external bus input
- dout  out  16  external bus output
- isout  out  1  bus direction (1 = drive dout)
- we  out  1  write strobe
- oe  out  1  output enable (posedge domain)
- oe_negedge, ale0_negedge, ale1_negedge  out  1 each  half-cycle-shifted strobes
- ble, bhe  out  1 each  byte lane enables (active high)
- ext_rdy  in  1  external ready

Behaviour:
- Interface fixed: single clock clk; reset rstn is synchronous, active-low. Negedge flops also clear when rstn is sampled low.
- Reset values: all outputs 0; ready=1 after first edge with rstn high; FSM in IDLE.
- States: IDLE, T1, T2, TW, T3.
- IDLE
  - On accept, latch addri/dtw/rw/size.
  - Misaligned request (halfword with addr[0]=1, word with addr[1:0]!=0) or size=11: no bus cycle; next cycle done=1, err=1, dtr=0, back in IDLE.
  - Otherwise go to T1.
- T1: dout=addr[16:1], isout=1, ale0_negedge=1 from the preceding negedge.
- T2: dout={1'b0, addr[31:17]}, we=rw, ale0_negedge=0, ale1_negedge=1.
- TW
  - isout=rw, dout=write halfword or 0, oe=!rw, lanes driven, ale1_negedge=0, oe_negedge=1.
  - Stay WAIT_STATES cycles. On the last cycle, if RDY_EN and ext_rdy=0, hold TW; leave on the first edge with ext_rdy=1.
- T3
  - Capture din for reads; drop we/oe, isout=0; oe_negedge=0 at next negedge.
  - Word access with first half pending: addr += 2, go to T1.
  - Otherwise go to IDLE with done=1.
- Lanes
  - byte even: ble=1, bhe=0, data on [7:0].
  - byte odd: ble=0, bhe=1, data on [15:8]; read returns dtr[7:0]=din[15:8].
  - halfword: both lanes set.
  - word: low half (addr) first, then high half (addr+2); dtr={second din, first din}.
- Latency, W=WAIT_STATES, no stretching, counted from accept edge k:
  - byte/halfword: done high after edge k+3+W.
  - word: done high after edge k+6+2W.
- ready=0 outside IDLE; valid while busy is ignored, not queued.
- The done cycle is IDLE, so a new request may be accepted in the same cycle done is high.
- dtr holds its value until the next read completes; err=0 whenever done=0.
- rstn low mid-transfer: abort on that edge, all strobes 0, no done pulse, word second half discarded.

Decomposition:
- Package ext_bus_pkg: FSM state enum, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), wait-counter width constant.
- One sub-module: ext_sram_waitctr, a loadable down-counter with ext_rdy hold, asserting tw_last.

Test Plan:
- Halfword read, W=1, addr=0x0001_2344, din=0xBEEF in TW: dout=0x91A2 in T1, dout=0x0000 in T2, oe=1 in TW; done 5 cycles after accept; dtr=0x0000_BEEF, err=0.
- Word write, W=2, addr=0x100, dtw=0xCAFEBABE: two bus cycles, dout=0xBABE then 0xCAFE, second T1 dout=0x0081; we high in T2–TW only; done after edge k+10.
- Byte read at odd addr 0x3, din=0x5A00: ble=0, bhe=1; dtr=0x0000_005A.
- Halfword at addr 0x1 and size=11: no ale/we/oe activity; done=1, err=1 on the next cycle.
- RDY_EN=1, ext_rdy low for 3 cycles in the final TW: TW extends exactly 3 cycles, then done.
- rstn low during a word write's second T2: all outputs 0 on that edge, no done; a new request after reset completes normally.
